// File: rtl/ring_counter_checker.sv
// Ring counter receive-side checker: decodes a one-hot rotating code to an index,
// verifies single-step advance, and tracks lock/error status with a saturating error count.
module ring_counter_checker #(
  parameter int N        = 4,
  parameter bit DIR      = 1'b0,
  parameter int LOCK_CNT = 2,
  parameter int CW       = 8,
  localparam int W       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  ring_in,
  output logic [W-1:0]  idx,
  output logic          locked,
  output logic          err,
  output logic          code_bad,
  output logic [CW-1:0] err_count
);

  localparam int RW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t        r_state;
  logic [RW-1:0] r_run;
  logic [N-1:0]  r_prev;

  int            w_ones;
  logic [W-1:0]  w_pos;
  logic          w_onehot;
  logic [N-1:0]  w_expected;
  logic          w_match;

  always_comb begin
    w_ones = 0;
    w_pos  = '0;
    for (int i = 0; i < N; i++) begin
      if (ring_in[i]) begin
        w_ones = w_ones + 1;
        w_pos  = W'(i);
      end
    end
  end

  assign w_onehot = (w_ones == 1);

  // prev is all-zero after reset, so nothing can match until a capture happens
  generate
    if (DIR == 1'b0) begin : g_left
      assign w_expected = {r_prev[N-2:0], r_prev[N-1]};
    end else begin : g_right
      assign w_expected = {r_prev[0], r_prev[N-1:1]};
    end
  endgenerate

  assign w_match = w_onehot && (ring_in == w_expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= HUNT;
      r_run     <= '0;
      r_prev    <= '0;
      idx       <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      code_bad  <= 1'b0;
      err_count <= '0;
    end else begin
      err      <= 1'b0;
      code_bad <= 1'b0;
      if (en) begin
        case (r_state)
          HUNT: begin
            if (w_onehot) begin
              r_prev  <= ring_in;
              idx     <= w_pos;
              r_run   <= '0;
              r_state <= VERIFY;
            end else begin
              code_bad <= 1'b1;
            end
          end
          VERIFY: begin
            if (w_match) begin
              r_prev <= ring_in;
              idx    <= w_pos;
              if (r_run == RW'(LOCK_CNT - 1)) begin
                r_run   <= '0;
                r_state <= LOCKED;
                locked  <= 1'b1;
              end else begin
                r_run <= r_run + RW'(1);
              end
            end else if (w_onehot) begin
              r_prev <= ring_in;
              idx    <= w_pos;
              r_run  <= '0;
            end else begin
              code_bad <= 1'b1;
              r_state  <= HUNT;
            end
          end
          LOCKED: begin
            if (w_match) begin
              r_prev <= ring_in;
              idx    <= w_pos;
            end else begin
              err     <= 1'b1;
              locked  <= 1'b0;
              r_state <= HUNT;
              if (err_count != {CW{1'b1}}) err_count <= err_count + CW'(1);
              // a clean-but-wrong code is still a valid position worth reporting
              if (w_onehot) begin
                r_prev <= ring_in;
                idx    <= w_pos;
              end else begin
                code_bad <= 1'b1;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_counter_checker.sv
// Self-checking bench: two checker instances (N=4 left, N=8 right with CW=2) driven by
// directed scenarios and random stimulus, compared against a position-based reference model.
module tb_ring_counter_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] ring_a;
  logic [7:0] ring_b;

  logic [1:0] idx_a;
  logic       locked_a, err_a, cb_a;
  logic [7:0] cnt_a;
  logic [2:0] idx_b;
  logic       locked_b, err_b, cb_b;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  ring_counter_checker #(.N(4), .DIR(1'b0), .LOCK_CNT(2), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .ring_in(ring_a),
    .idx(idx_a), .locked(locked_a), .err(err_a), .code_bad(cb_a), .err_count(cnt_a)
  );

  ring_counter_checker #(.N(8), .DIR(1'b1), .LOCK_CNT(2), .CW(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .ring_in(ring_b),
    .idx(idx_b), .locked(locked_b), .err(err_b), .code_bad(cb_b), .err_count(cnt_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: position-based, one entry per instance (0 = dut_a, 1 = dut_b)
  int mN[2]   = '{4, 8};
  int mDir[2] = '{0, 1};
  int mMax[2] = '{255, 3};
  localparam int LOCK = 2;
  int m_mode[2];   // 0 hunting, 1 verifying, 2 locked
  int m_run[2];
  int m_prev[2];   // last accepted position, -1 if none
  int m_idx[2];
  int m_err[2];
  int m_cb[2];
  int m_cnt[2];

  task automatic m_reset();
    for (int u = 0; u < 2; u++) begin
      m_mode[u] = 0; m_run[u] = 0; m_prev[u] = -1; m_idx[u] = 0;
      m_err[u] = 0; m_cb[u] = 0; m_cnt[u] = 0;
    end
  endtask

  function automatic int next_pos(input int u);
    if (m_prev[u] < 0) return -1;
    return (mDir[u] == 0) ? (m_prev[u] + 1) % mN[u] : (m_prev[u] + mN[u] - 1) % mN[u];
  endfunction

  task automatic m_step(input int u, input logic e, input logic [7:0] r);
    int  ones = 0;
    int  k = -1;
    bit  oh, match;
    m_err[u] = 0;
    m_cb[u]  = 0;
    if (!e) return;
    for (int i = 0; i < mN[u]; i++) if (r[i]) begin ones++; k = i; end
    oh    = (ones == 1);
    match = oh && (k == next_pos(u));
    case (m_mode[u])
      0: if (oh) begin m_prev[u] = k; m_idx[u] = k; m_run[u] = 0; m_mode[u] = 1; end
         else m_cb[u] = 1;
      1: if (match) begin
           m_prev[u] = k; m_idx[u] = k; m_run[u]++;
           if (m_run[u] == LOCK) m_mode[u] = 2;
         end else if (oh) begin
           m_prev[u] = k; m_idx[u] = k; m_run[u] = 0;
         end else begin
           m_cb[u] = 1; m_mode[u] = 0;
         end
      default: if (match) begin
           m_prev[u] = k; m_idx[u] = k;
         end else begin
           m_err[u] = 1;
           m_cnt[u] = (m_cnt[u] < mMax[u]) ? m_cnt[u] + 1 : mMax[u];
           if (oh) begin m_prev[u] = k; m_idx[u] = k; end
           else m_cb[u] = 1;
           m_mode[u] = 0;
         end
    endcase
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".a.idx"},    int'(idx_a),    m_idx[0]);
    check({ph, ".a.locked"}, int'(locked_a), int'(m_mode[0] == 2));
    check({ph, ".a.err"},    int'(err_a),    m_err[0]);
    check({ph, ".a.cb"},     int'(cb_a),     m_cb[0]);
    check({ph, ".a.cnt"},    int'(cnt_a),    m_cnt[0]);
    check({ph, ".b.idx"},    int'(idx_b),    m_idx[1]);
    check({ph, ".b.locked"}, int'(locked_b), int'(m_mode[1] == 2));
    check({ph, ".b.err"},    int'(err_b),    m_err[1]);
    check({ph, ".b.cb"},     int'(cb_b),     m_cb[1]);
    check({ph, ".b.cnt"},    int'(cnt_b),    m_cnt[1]);
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    m_step(0, en, {4'b0000, ring_a});
    m_step(1, en, ring_b);
    #1;
    compare_all(ph);
  endtask

  task automatic drive(input string ph, input logic e, input logic [3:0] a, input logic [7:0] b);
    en = e; ring_a = a; ring_b = b;
    tick(ph);
  endtask

  function automatic logic [7:0] clean_code(input int u);
    int p = (m_prev[u] < 0) ? ((u == 0) ? 0 : 7) : next_pos(u);
    return 8'(1) << p;
  endfunction

  function automatic logic [7:0] rand_code(input int u);
    int n = mN[u];
    int sel = int'($urandom_range(0, 9));
    logic [7:0] mask = 8'((1 << n) - 1);
    int p;
    if (sel <= 5) begin
      p = (m_prev[u] < 0) ? int'($urandom % n) : next_pos(u);
      return 8'(1) << p;
    end else if (sel == 6) begin
      p = (m_prev[u] < 0) ? 0 : ((mDir[u] == 0) ? (m_prev[u] + 2) % n : (m_prev[u] + n - 2) % n);
      return 8'(1) << p;
    end else if (sel == 7) begin
      return 8'(1) << ($urandom % n);
    end else if (sel == 8) begin
      return 8'h00;
    end
    return 8'($urandom) & mask;
  endfunction

  // Assert reset between edges, check immediate clear, release before the next edge
  task automatic mid_cycle_reset(input string ph);
    #2 rst = 1'b1;
    #1;
    m_reset();
    compare_all(ph);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ring_a = '0; ring_b = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // Clean lock on dut_a
    drive("lock", 1'b1, 4'b0001, clean_code(1));
    drive("lock", 1'b1, 4'b0010, clean_code(1));
    drive("lock", 1'b1, 4'b0100, clean_code(1));
    check("lock.locked", int'(locked_a), 1);
    check("lock.idx", int'(idx_a), 2);
    drive("lock", 1'b1, 4'b1000, clean_code(1));
    check("lock.idx3", int'(idx_a), 3);
    drive("lock", 1'b1, 4'b0001, clean_code(1));
    check("lock.wrap_idx", int'(idx_a), 0);
    check("lock.wrap_locked", int'(locked_a), 1);

    // Skip error while locked at 0001
    drive("skip", 1'b1, 4'b0100, clean_code(1));
    check("skip.err", int'(err_a), 1);
    check("skip.cnt", int'(cnt_a), 1);
    check("skip.locked", int'(locked_a), 0);
    check("skip.idx", int'(idx_a), 2);
    drive("skip", 1'b1, 4'b0001, clean_code(1));
    check("skip.err_once", int'(err_a), 0);
    drive("skip", 1'b1, 4'b0010, clean_code(1));
    drive("skip", 1'b1, 4'b0100, clean_code(1));
    check("skip.relock", int'(locked_a), 1);
    check("skip.cnt_hold", int'(cnt_a), 1);

    // Multi-hot while locked, then zero code while verifying
    drive("bad", 1'b1, 4'b1000, clean_code(1));
    drive("bad", 1'b1, 4'b0011, clean_code(1));
    check("bad.err", int'(err_a), 1);
    check("bad.cb", int'(cb_a), 1);
    check("bad.cnt", int'(cnt_a), 2);
    check("bad.idx_hold", int'(idx_a), 3);
    drive("bad", 1'b1, 4'b0001, clean_code(1));
    drive("bad", 1'b1, 4'b0000, clean_code(1));
    check("bad.cb_verify", int'(cb_a), 1);
    check("bad.no_err", int'(err_a), 0);
    check("bad.cnt_same", int'(cnt_a), 2);

    // Relock at 0010 then gate enable with garbage on the bus
    drive("gate", 1'b1, 4'b1000, clean_code(1));
    drive("gate", 1'b1, 4'b0001, clean_code(1));
    drive("gate", 1'b1, 4'b0010, clean_code(1));
    for (int i = 0; i < 3; i++) begin
      drive("gate", 1'b0, 4'b1111, 8'hFF);
      check("gate.locked", int'(locked_a), 1);
      check("gate.idx", int'(idx_a), 1);
      check("gate.cb", int'(cb_a), 0);
    end
    drive("gate", 1'b1, 4'b0100, clean_code(1));
    check("gate.resume_idx", int'(idx_a), 2);
    check("gate.resume_locked", int'(locked_a), 1);

    // Right-rotating N=8 instance: repeated skips saturate the 2-bit counter
    check("sat.pre_locked", int'(locked_b), 1);
    for (int r = 0; r < 5; r++) begin
      drive("sat", 1'b1, 8'(clean_code(0)), 8'(1) << ((m_prev[1] + 6) % 8));
      check("sat.err", int'(err_b), 1);
      check("sat.cnt", int'(cnt_b), (r + 1 < 3) ? r + 1 : 3);
      for (int j = 0; j < 3; j++) drive("sat", 1'b1, 8'(clean_code(0)), clean_code(1));
      check("sat.relock", int'(locked_b), 1);
    end

    // Async reset while dut_a is locked with two errors recorded
    check("arst.pre_cnt", int'(cnt_a), 2);
    check("arst.pre_locked", int'(locked_a), 1);
    mid_cycle_reset("arst");
    check("arst.idx", int'(idx_a), 0);
    check("arst.locked", int'(locked_a), 0);
    check("arst.cnt", int'(cnt_a), 0);
    drive("arst", 1'b1, 4'b0001, clean_code(1));
    drive("arst", 1'b1, 4'b0010, clean_code(1));
    check("arst.not_yet", int'(locked_a), 0);
    drive("arst", 1'b1, 4'b0100, clean_code(1));
    check("arst.relock", int'(locked_a), 1);

    // Random traffic with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      en     = ($urandom_range(0, 99) < 85);
      ring_a = 4'(rand_code(0));
      ring_b = rand_code(1);
      tick("rand");
      if ($urandom_range(0, 199) == 0) mid_cycle_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ring_counter_checker.md
# ring_counter_checker

Receive-side companion to the ring counter: samples a one-hot rotating code each enabled clock, decodes it to a binary index, and verifies that it advances by exactly one position per sample. A small lock state machine declares the sequence trustworthy after a run of correct steps. Errors are flagged and counted once locked. It sits at the consumer end of any ring-counter-driven sequencing path, as a decoder and live integrity monitor.

## Interface
- N, 4: ring width in bits (N ≥ 2); W = $clog2(N) is the index width.
- DIR, 0: rotation direction. 0 = left, bit i → bit i+1, with bit N-1 wrapping to bit 0. 1 = right, bit i → bit i-1, with bit 0 wrapping to bit N-1.
- LOCK_CNT, 2: consecutive correct steps required to lock (≥ 1).
- CW, 8: error-counter width.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample qualifier; ring_in is ignored while low.
- ring_in  in  N  ring code under test.
- idx  out  W  index of the set bit in the last accepted one-hot sample.
- locked  out  1  high while the FSM is in LOCKED.
- err  out  1  one-cycle pulse: a sequence error was detected while LOCKED.
- code_bad  out  1  one-cycle pulse: an enabled sample was not one-hot (zero or multi-hot), in any state.
- err_count  out  CW  number of err pulses, saturating at 2^CW−1.

## Operation
- A sample is a rising edge with en=1.
- onehot means exactly one bit of ring_in is set.
- expected = rotate(prev, DIR), where prev is the last accepted one-hot sample.
- match means onehot && ring_in == expected. The wrap cases (e.g. 1000 → 0001 for N=4, DIR=0) are matches.
- FSM states: HUNT (reset state), VERIFY, LOCKED. A run counter (0..LOCK_CNT) is used only in VERIFY.
- HUNT:
  - Sample with onehot: capture prev/idx, set run=0, go to VERIFY.
  - Sample without onehot: pulse code_bad, stay in HUNT.
- VERIFY:
  - match: capture, run++. If run reaches LOCK_CNT, go to LOCKED.
  - onehot but not match: capture as a new start, set run=0, stay in VERIFY.
  - not onehot: pulse code_bad, go to HUNT.
  - No err pulse is raised from VERIFY.
- LOCKED:
  - match: capture and stay.
  - Any other sample: pulse err, increment err_count (saturating), go to HUNT.
    - If the sample was not onehot, also pulse code_bad.
    - If it was onehot, capture it into prev/idx. It does not count as a VERIFY start; the FSM re-enters via HUNT on the next sample.
- en=0: state, run, prev, idx and err_count all hold. err and code_bad are 0.
- idx updates only on accepted onehot samples. Bit position k maps to idx=k.
- err_count never wraps; once at 2^CW−1 it stays there until reset.

## Timing
- All outputs are registered. The response to a sample is visible after that sample's clock edge (1-cycle latency).
- locked rises after the edge that samples the LOCK_CNT-th consecutive match. For LOCK_CNT=2 that is the 3rd clean sample after entering HUNT.
- locked falls after the edge that samples the first error. err is high for exactly that one cycle. err_count shows the incremented value in the same cycle.
- Back-to-back errors cannot both come from LOCKED: the second bad sample arrives in HUNT.
- rst asserted at any time, including mid-lock or mid-pulse, immediately forces:
  - state=HUNT, run=0, prev=0
  - idx=0, locked=0, err=0, code_bad=0, err_count=0
  These values hold until the first rising edge after rst deasserts.
- Simultaneous rst and en: reset wins.

## Test plan
- Clean lock (N=4, DIR=0, LOCK_CNT=2): after reset, drive 0001, 0010, 0100, 1000, 0001 on consecutive cycles → locked=1 after the 3rd edge with idx=2. The next two edges give idx=3 then idx=0, locked stays 1, err never asserts.
- Skip error: while locked at 0001, drive 0100 → err=1 for one cycle, err_count=1, locked=0, idx=2. Then 0001, 0010, 0100 → locked=1 again, err_count remains 1.
- Bad codes: in VERIFY drive 0000 → code_bad pulse, state HUNT, err_count unchanged. While locked drive 0011 → err and code_bad both pulse, err_count+1, idx unchanged.
- Enable gating: while locked at 0010, hold en=0 for 3 cycles with ring_in=1111 → no pulses, locked=1, idx=1. Then en=1 with 0100 → stays locked, idx=2.
- Direction and saturation (N=8, DIR=1, CW=2): drive 10000000, 01000000, 00100000 → locked. Then repeat five times: one skip error followed by three clean samples to relock → err_count reads 1, 2, 3, 3, 3.
- Async reset mid-operation: while locked with err_count=2, assert rst between clock edges → idx, locked and err_count read 0 before the next edge. After release, relock requires the full LOCK_CNT+1 clean samples.
